// File: rtl/sampler_pkg.sv
// Shared types and default widths for the sampler voice path
// (scheduler, keymappers, address incrementer).
package sampler_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        READ,
        ACCUM,
        OUTPUT
    } sched_state_t;

    localparam int SAMPLE_ADDR_W = 20;
    localparam int SAMPLE_DATA_W = 16;

endpackage

// File: rtl/mix_saturator.sv
// Combinational clamp of the wide mix accumulator down to the DAC sample width.
module mix_saturator #(
    parameter int ACC_W  = 18,
    parameter int DATA_W = 16
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] sat
);

    // The value fits when every bit above the target sign bit matches it.
    function automatic logic signed [DATA_W-1:0] clamp(input logic signed [ACC_W-1:0] v);
        logic [ACC_W-DATA_W:0] hi;
        hi = v[ACC_W-1:DATA_W-1];
        if (&hi || ~|hi)
            clamp = v[DATA_W-1:0];
        else if (v[ACC_W-1])
            clamp = {1'b1, {(DATA_W-1){1'b0}}};
        else
            clamp = {1'b0, {(DATA_W-1){1'b1}}};
    endfunction

    assign sat = clamp(acc);

endmodule

// File: rtl/sampler_voice_scheduler.sv
// Walks the voices once per sample_clk frame, fetching one word per active voice
// over the shared memory read port and emitting a saturated mix sample.
module sampler_voice_scheduler
    import sampler_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int ADDR_W     = SAMPLE_ADDR_W,
    parameter int DATA_W     = SAMPLE_DATA_W
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         sample_clk,
    input  logic [NUM_VOICES-1:0]        voice_active,
    input  logic [NUM_VOICES*ADDR_W-1:0] voice_addr,
    output logic [NUM_VOICES-1:0]        voice_step,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic                         mem_rd,
    input  logic                         mem_ack,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic [DATA_W-1:0]            mix_out,
    output logic                         mix_valid,
    output logic                         overrun,
    input  logic                         overrun_clr
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int ACC_W = DATA_W + IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    sched_state_t             state, state_nxt;
    logic                     sc_q;
    logic                     frame_edge;
    logic                     is_last;
    logic [NUM_VOICES-1:0]    act_q;
    logic [IDX_W-1:0]         idx;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] rdata_q;
    logic signed [DATA_W-1:0] mix_q;
    logic signed [DATA_W-1:0] mix_sat;
    logic [ADDR_W-1:0]        addr_arr [NUM_VOICES];

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_addr
        assign addr_arr[g] = voice_addr[g*ADDR_W +: ADDR_W];
    end

    assign frame_edge = sample_clk & ~sc_q;
    assign is_last    = (idx == LAST_IDX);

    always_ff @(posedge Clk) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // voice_addr only moves on voice_step, which ends READ, so mem_addr is stable while mem_rd is high.
    always_comb begin
        state_nxt  = state;
        mem_rd     = 1'b0;
        mem_addr   = '0;
        voice_step = '0;
        mix_valid  = 1'b0;
        mix_out    = mix_q;
        case (state)
            IDLE: begin
                if (frame_edge)
                    state_nxt = SCAN;
            end
            SCAN: begin
                if (act_q[idx])
                    state_nxt = READ;
                else if (is_last)
                    state_nxt = OUTPUT;
            end
            READ: begin
                mem_rd   = 1'b1;
                mem_addr = addr_arr[idx];
                if (mem_ack) begin
                    voice_step[idx] = 1'b1;
                    state_nxt       = ACCUM;
                end
            end
            ACCUM: begin
                state_nxt = is_last ? OUTPUT : SCAN;
            end
            OUTPUT: begin
                mix_valid = 1'b1;
                mix_out   = mix_sat;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sc_q    <= 1'b0;
            overrun <= 1'b0;
            mix_q   <= '0;
        end else begin
            sc_q <= sample_clk;
            if (frame_edge && state != IDLE)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;
            if (state == OUTPUT)
                mix_q <= mix_sat;
        end
    end

    // Datapath registers are (re)initialised at every frame start and need no reset.
    always_ff @(posedge Clk) begin
        if (state == IDLE && frame_edge) begin
            act_q <= voice_active;
            idx   <= '0;
            acc   <= '0;
        end
        if (state == SCAN && !act_q[idx] && !is_last)
            idx <= idx + 1'b1;
        if (state == READ && mem_ack)
            rdata_q <= mem_rdata;
        if (state == ACCUM) begin
            acc <= acc + ACC_W'(rdata_q);
            if (!is_last)
                idx <= idx + 1'b1;
        end
    end

    mix_saturator #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W)
    ) u_mix_saturator (
        .acc (acc),
        .sat (mix_sat)
    );

endmodule

// File: tb/tb_sampler_voice_scheduler.sv
// Randomised self-checking bench for sampler_voice_scheduler with a frame-level reference model.
module tb_sampler_voice_scheduler;

    localparam int NV = 4;
    localparam int AW = 20;
    localparam int DW = 16;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic             sample_clk = 1'b0;
    logic [NV-1:0]    voice_active = '0;
    logic [NV*AW-1:0] voice_addr = '0;
    logic [NV-1:0]    voice_step;
    logic [AW-1:0]    mem_addr;
    logic             mem_rd;
    logic             mem_ack = 1'b0;
    logic [DW-1:0]    mem_rdata = '0;
    logic [DW-1:0]    mix_out;
    logic             mix_valid;
    logic             overrun;
    logic             overrun_clr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    sampler_voice_scheduler #(.NUM_VOICES(NV), .ADDR_W(AW), .DATA_W(DW)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .sample_clk   (sample_clk),
        .voice_active (voice_active),
        .voice_addr   (voice_addr),
        .voice_step   (voice_step),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .mix_out      (mix_out),
        .mix_valid    (mix_valid),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr)
    );

    // Per-voice sample memory contents and addresses
    logic [AW-1:0] va [NV];
    logic [DW-1:0] dv [NV];
    logic [NV-1:0] frame_act;

    // Observations from one frame
    logic [AW-1:0] obs_addr [$];
    int            obs_len  [$];
    logic [NV-1:0] obs_step [$];
    int            obs_valid_k;
    int            obs_valid_n;
    logic [DW-1:0] obs_mix;
    bit            obs_unstable;
    bit            obs_stray_step;

    function automatic logic [DW-1:0] lookup(input logic [AW-1:0] a);
        for (int j = 0; j < NV; j++)
            if (va[j] == a) return dv[j];
        return 16'hDEAD;
    endfunction

    function automatic int exp_latency(input logic [NV-1:0] act, input int w);
        int s = 0;
        for (int i = 0; i < NV; i++) s += act[i] ? (3 + w) : 1;
        return s + 1;
    endfunction

    function automatic logic [DW-1:0] exp_mix(input logic [NV-1:0] act);
        int s = 0;
        for (int i = 0; i < NV; i++)
            if (act[i]) s += int'($signed(dv[i]));
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return s[DW-1:0];
    endfunction

    task automatic apply_addrs();
        for (int i = 0; i < NV; i++) voice_addr[i*AW +: AW] = va[i];
    endtask

    task automatic random_addrs();
        for (int i = 0; i < NV; i++) va[i] = AW'((i << 18) | $urandom_range(0, 32'h3FFFF));
        apply_addrs();
    endtask

    // Raise sample_clk, then act as the memory for `budget` cycles, logging what the DUT does.
    task automatic run_frame(input int w, input int budget, input int edge2_k, input bit stray, input bit scramble);
        int            rd_cnt;
        logic [AW-1:0] cur_addr;
        obs_addr.delete(); obs_len.delete(); obs_step.delete();
        obs_valid_k = -1; obs_valid_n = 0; obs_mix = 'x;
        obs_unstable = 0; obs_stray_step = 0;
        rd_cnt = 0; cur_addr = '0;
        frame_act = voice_active;
        @(negedge Clk);
        sample_clk = 1'b1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge Clk);
            if (k == 1) sample_clk = 1'b0;
            if (edge2_k > 0 && k == edge2_k) sample_clk = 1'b1;
            if (edge2_k > 0 && k == edge2_k + 1) sample_clk = 1'b0;
            if (scramble && k == 2) voice_active = NV'($urandom);
            mem_ack = 1'b0;
            if (mix_valid) begin
                obs_valid_n++;
                if (obs_valid_k < 0) obs_valid_k = k;
                obs_mix = mix_out;
            end
            if (mem_rd) begin
                if (rd_cnt == 0) begin
                    obs_addr.push_back(mem_addr);
                    cur_addr = mem_addr;
                end else if (mem_addr !== cur_addr) begin
                    obs_unstable = 1;
                end
                rd_cnt++;
                if (rd_cnt == w + 1) begin
                    mem_ack   = 1'b1;
                    mem_rdata = lookup(mem_addr);
                    obs_len.push_back(rd_cnt);
                    rd_cnt = 0;
                end
            end else if (stray && (k % 3 == 0)) begin
                mem_ack   = 1'b1;
                mem_rdata = 16'h7FFF;
            end
            #1;
            if (voice_step !== '0) begin
                obs_step.push_back(voice_step);
                if (!(mem_rd && mem_ack)) obs_stray_step = 1;
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        n_checks += 6;
        if (mem_rd !== 1'b0)    begin n_fail++; $display("FAIL reset_mem_rd got=%b exp=0", mem_rd); end
        if (mem_addr !== '0)    begin n_fail++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        if (voice_step !== '0)  begin n_fail++; $display("FAIL reset_voice_step got=%b exp=0", voice_step); end
        if (mix_out !== '0)     begin n_fail++; $display("FAIL reset_mix_out got=%h exp=0", mix_out); end
        if (mix_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mix_valid got=%b exp=0", mix_valid); end
        if (overrun !== 1'b0)   begin n_fail++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        Reset = 1'b0;
    endtask

    task automatic test_no_voices();
        voice_active = '0;
        random_addrs();
        run_frame(0, 10, 0, 0, 0);
        n_checks += 5;
        if (obs_addr.size() != 0) begin n_fail++; $display("FAIL idle_reads got=%0d exp=0", obs_addr.size()); end
        if (obs_step.size() != 0) begin n_fail++; $display("FAIL idle_steps got=%0d exp=0", obs_step.size()); end
        if (obs_valid_k != 5)     begin n_fail++; $display("FAIL idle_latency got=%0d exp=5", obs_valid_k); end
        if (obs_valid_n != 1)     begin n_fail++; $display("FAIL idle_valid_count got=%0d exp=1", obs_valid_n); end
        if (obs_mix !== 16'h0000) begin n_fail++; $display("FAIL idle_mix got=%h exp=0000", obs_mix); end
    endtask

    task automatic test_two_voices();
        va[0] = 20'h00001; va[1] = 20'h00100; va[2] = 20'h10002; va[3] = 20'h20000;
        dv[0] = 16'h1111;  dv[1] = 16'h0100;  dv[2] = 16'h2222;  dv[3] = 16'hFF00;
        apply_addrs();
        voice_active = 4'b1010;
        run_frame(0, 14, 0, 0, 0);
        n_checks += 4;
        if (obs_addr.size() != 2 || obs_addr[0] !== 20'h00100 || obs_addr[1] !== 20'h20000) begin
            n_fail++; $display("FAIL two_addrs got=%p exp=00100,20000", obs_addr);
        end
        if (obs_step.size() != 2 || obs_step[0] !== 4'b0010 || obs_step[1] !== 4'b1000) begin
            n_fail++; $display("FAIL two_steps got=%p exp=0010,1000", obs_step);
        end
        if (obs_mix !== 16'h0000) begin n_fail++; $display("FAIL two_mix got=%h exp=0000", obs_mix); end
        if (obs_valid_k != exp_latency(4'b1010, 0)) begin
            n_fail++; $display("FAIL two_latency got=%0d exp=%0d", obs_valid_k, exp_latency(4'b1010, 0));
        end
    endtask

    task automatic test_saturation();
        random_addrs();
        voice_active = 4'b0011;
        dv[0] = 16'h7000; dv[1] = 16'h7000;
        run_frame(0, 14, 0, 0, 0);
        n_checks++;
        if (obs_mix !== 16'h7FFF) begin n_fail++; $display("FAIL sat_pos got=%h exp=7fff", obs_mix); end
        dv[0] = 16'h9000; dv[1] = 16'h9000;
        run_frame(0, 14, 0, 0, 0);
        n_checks++;
        if (obs_mix !== 16'h8000) begin n_fail++; $display("FAIL sat_neg got=%h exp=8000", obs_mix); end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        int bad  = 0;
        random_addrs();
        voice_active = 4'b0001;
        @(negedge Clk);
        sample_clk = 1'b1;
        for (int k = 1; k <= 10 && !seen; k++) begin
            @(negedge Clk);
            if (k == 1) sample_clk = 1'b0;
            if (mem_rd) seen = 1;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL rstmid_read_start got=0 exp=1"); end
        Reset = 1'b1;
        @(negedge Clk);
        #1;
        n_checks += 4;
        if (mem_rd !== 1'b0)    begin n_fail++; $display("FAIL rstmid_mem_rd got=%b exp=0", mem_rd); end
        if (mix_out !== '0)     begin n_fail++; $display("FAIL rstmid_mix_out got=%h exp=0", mix_out); end
        if (mix_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_mix_valid got=%b exp=0", mix_valid); end
        if (voice_step !== '0)  begin n_fail++; $display("FAIL rstmid_step got=%b exp=0", voice_step); end
        Reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            if (mix_valid || mem_rd) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL rstmid_quiet got=%0d exp=0", bad); end
        voice_active = 4'b0101;
        dv[0] = 16'($urandom); dv[2] = 16'($urandom);
        run_frame(1, 16, 0, 0, 0);
        n_checks += 2;
        if (obs_mix !== exp_mix(4'b0101)) begin n_fail++; $display("FAIL rstmid_clean_mix got=%h exp=%h", obs_mix, exp_mix(4'b0101)); end
        if (obs_valid_k != exp_latency(4'b0101, 1)) begin
            n_fail++; $display("FAIL rstmid_clean_latency got=%0d exp=%0d", obs_valid_k, exp_latency(4'b0101, 1));
        end
    endtask

    task automatic test_wait_states();
        int bad = 0;
        random_addrs();
        voice_active = 4'b0001;
        dv[0] = 16'($urandom);
        run_frame(5, 18, 0, 1, 0);
        n_checks += 4;
        if (obs_len.size() != 1 || obs_len[0] != 6) begin n_fail++; $display("FAIL wait_rd_len got=%p exp=6", obs_len); end
        if (obs_step.size() != 1 || obs_step[0] !== 4'b0001 || obs_stray_step) begin
            n_fail++; $display("FAIL wait_step got=%p stray=%0d exp=0001", obs_step, obs_stray_step);
        end
        if (obs_unstable) begin n_fail++; $display("FAIL wait_addr_stable got=unstable exp=stable"); end
        if (obs_mix !== exp_mix(4'b0001)) begin n_fail++; $display("FAIL wait_mix got=%h exp=%h", obs_mix, exp_mix(4'b0001)); end
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            mem_ack = 1'b1; mem_rdata = 16'h4444;
            #1;
            if (mem_rd || voice_step !== '0 || mix_valid) bad++;
        end
        @(negedge Clk);
        mem_ack = 1'b0;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL idle_stray_ack got=%0d exp=0", bad); end
    endtask

    task automatic test_overrun();
        random_addrs();
        voice_active = 4'b0001;
        dv[0] = 16'($urandom);
        run_frame(5, 22, 4, 0, 0);
        n_checks += 4;
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set got=%b exp=1", overrun); end
        if (obs_valid_n != 1) begin n_fail++; $display("FAIL ovr_valid_count got=%0d exp=1", obs_valid_n); end
        if (obs_addr.size() != 1) begin n_fail++; $display("FAIL ovr_no_second_frame got=%0d reads exp=1", obs_addr.size()); end
        if (obs_valid_k != exp_latency(4'b0001, 5)) begin
            n_fail++; $display("FAIL ovr_latency got=%0d exp=%0d", obs_valid_k, exp_latency(4'b0001, 5));
        end
        @(negedge Clk); overrun_clr = 1'b1;
        @(negedge Clk); overrun_clr = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 10; f++) begin
            logic [NV-1:0] act;
            int            w;
            logic [AW-1:0] exp_a [$];
            logic [NV-1:0] exp_s [$];
            bit            ok_a, ok_s;
            act = NV'($urandom);
            w   = $urandom_range(0, 3);
            random_addrs();
            for (int i = 0; i < NV; i++) dv[i] = 16'($urandom);
            voice_active = act;
            for (int i = 0; i < NV; i++)
                if (act[i]) begin exp_a.push_back(va[i]); exp_s.push_back(NV'(1 << i)); end
            run_frame(w, exp_latency(act, w) + 4, 0, 1'($urandom), 1);
            ok_a = (obs_addr.size() == exp_a.size());
            ok_s = (obs_step.size() == exp_s.size()) && !obs_stray_step;
            for (int i = 0; i < exp_a.size() && ok_a; i++) if (obs_addr[i] !== exp_a[i]) ok_a = 0;
            for (int i = 0; i < exp_s.size() && ok_s; i++) if (obs_step[i] !== exp_s[i]) ok_s = 0;
            n_checks += 5;
            if (!ok_a) begin n_fail++; $display("FAIL rnd%0d_addrs got=%p exp=%p", f, obs_addr, exp_a); end
            if (!ok_s) begin n_fail++; $display("FAIL rnd%0d_steps got=%p exp=%p", f, obs_step, exp_s); end
            if (obs_mix !== exp_mix(act)) begin n_fail++; $display("FAIL rnd%0d_mix got=%h exp=%h", f, obs_mix, exp_mix(act)); end
            if (obs_valid_k != exp_latency(act, w) || obs_valid_n != 1) begin
                n_fail++; $display("FAIL rnd%0d_latency got=%0d/%0d exp=%0d/1", f, obs_valid_k, obs_valid_n, exp_latency(act, w));
            end
            if (obs_unstable) begin n_fail++; $display("FAIL rnd%0d_addr_stable got=unstable exp=stable", f); end
        end
        n_checks++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL rnd_no_overrun got=%b exp=0", overrun); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NV; i++) begin va[i] = '0; dv[i] = '0; end
        test_reset();
        test_no_voices();
        test_two_voices();
        test_saturation();
        test_reset_mid();
        test_wait_states();
        test_overrun();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sampler_voice_scheduler.md
# sampler_voice_scheduler

Time-multiplexes the single sample-memory read port among `NUM_VOICES` per-voice address generators once per audio sample period. On each `sample_clk` rising edge it walks the voices in index order. For each active voice it fetches one sample word and pulses that voice's step/increment strobe. It then sums the fetched words into one saturated 16-bit mix sample for the DAC path. It sits between the per-voice address controllers and the sample SRAM/SDRAM read interface.

## Interface
Parameters:
- `NUM_VOICES`, 4: number of voice address generators (≥2).
- `ADDR_W`, 20: sample memory address width.
- `DATA_W`, 16: signed sample width.

Ports:
- `Clk`  in  1  system clock.
- `Reset`  in  1  synchronous, active-high reset.
- `sample_clk`  in  1  audio-rate level, synchronous to `Clk`; rising edge starts a frame.
- `voice_active`  in  NUM_VOICES  per-voice note-on; latched at frame start.
- `voice_addr`  in  NUM_VOICES*ADDR_W  flattened per-voice current address; voice i at bits [i*ADDR_W +: ADDR_W].
- `voice_step`  out  NUM_VOICES  one-cycle pulse to voice i's address generator after its word is fetched.
- `mem_addr`  out  ADDR_W  read address; valid while `mem_rd`=1.
- `mem_rd`  out  1  read request; held until ack.
- `mem_ack`  in  1  read data valid this cycle.
- `mem_rdata`  in  DATA_W  signed read data; sampled when `mem_ack`=1.
- `mix_out`  out  DATA_W  signed saturated mix; holds between frames.
- `mix_valid`  out  1  one-cycle pulse when `mix_out` updates.
- `overrun`  out  1  sticky: frame start missed while busy.
- `overrun_clr`  in  1  clears `overrun`.

## Operation
- Edge detect: registered copy `sc_q` of `sample_clk`. Edge = `sample_clk & ~sc_q`.
- States: IDLE, SCAN, READ, ACCUM, OUTPUT.
- IDLE → SCAN on edge.
  - On that edge: latch `voice_active` into `act_q`, idx←0, acc←0.
- SCAN, voice idx:
  - If `act_q[idx]`=1 → READ.
  - Otherwise, if idx is last → OUTPUT; else idx+1 and stay in SCAN.
- READ:
  - `mem_rd`=1 and `mem_addr`=voice_addr[idx] for every cycle in READ.
  - On `mem_ack`: capture `mem_rdata`, pulse `voice_step[idx]` the same cycle, → ACCUM.
- ACCUM:
  - acc ← acc + sign-extended data.
  - If idx is last → OUTPUT; else idx+1 → SCAN.
- OUTPUT:
  - `mix_out` = sat(acc), `mix_valid`=1 for this one cycle.
  - → IDLE.
- Arithmetic:
  - acc is signed, DATA_W+$clog2(NUM_VOICES) bits; no overflow possible.
  - sat clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Boundary conditions:
  - Edge detected in any state other than IDLE: set `overrun`, ignore that edge. The current frame completes normally.
  - `overrun_clr` and an overrun event in the same cycle: set wins.
  - `mem_ack` outside READ is ignored.
  - `voice_active` changes mid-frame have no effect until the next frame.
  - No active voices: frame still runs; `mix_out`=0 with `mix_valid` pulse.
  - Reset mid-frame:
    - Next cycle: IDLE, `mem_rd`=0, no `voice_step`.
    - No `mix_valid` for the aborted frame; an outstanding read is abandoned.

## Timing
- Reset values:
  - `mem_rd`=0, `mem_addr`=0, `voice_step`=0.
  - `mix_out`=0, `mix_valid`=0, `overrun`=0.
  - state IDLE, `sc_q`=0.
- Edge seen in IDLE at cycle t → SCAN at t+1.
- Cycles per voice:
  - Inactive voice: 1 cycle (SCAN).
  - Active voice: SCAN 1 + READ (1 + wait cycles) + ACCUM 1. Zero-wait = 3 cycles.
- Frame length = 1 + Σ(voice cycles) + 1 (OUTPUT).
- N=4, all inactive: `mix_valid` at t+5.
- `mem_addr` is stable for every cycle `mem_rd`=1.
- The whole frame must end before the next `sample_clk` edge. Otherwise `overrun` is set.

## Structure
- `sampler_pkg` holds:
  - the `sched_state_t` enum (IDLE, SCAN, READ, ACCUM, OUTPUT);
  - default constants `SAMPLE_ADDR_W`=20 and `SAMPLE_DATA_W`=16, shared with the keymappers and address incrementer.
- One sub-module: `mix_saturator`.
  - Combinational clamp from the accumulator width to DATA_W, parameterised by both widths.
- The FSM, index counter, accumulator and edge detector live in the top module.

## Test plan
- N=4, no voices active, one `sample_clk` edge → no `mem_rd`, no `voice_step`; `mix_valid` exactly 5 cycles after the edge cycle; `mix_out`=0.
- Voices 1 and 3 active, addrs 0x00100/0x20000, data 0x0100/0xFF00 (−256), zero-wait ack → `mem_rd` with 0x00100 then 0x20000; `voice_step`=0010 then 1000; `mix_out`=0x0000.
- Voices 0 and 1 active, data 0x7000 each → `mix_out`=0x7FFF. Repeat with 0x9000 each → 0x8000.
- Voice 0 active, `mem_ack` delayed 5 cycles → `mem_rd` and `mem_addr` held 6 cycles; single `voice_step[0]` on the ack cycle; stray `mem_ack` in IDLE has no effect.
- Second `sample_clk` edge during READ → `overrun`=1; current frame still produces one `mix_valid`; no second frame starts; `overrun_clr` then returns it to 0.
- `Reset` asserted during READ → next cycle `mem_rd`=0, `mix_out`=0, no `mix_valid`; a new edge then runs a clean frame.
